// File: rtl/coco_bus_glue.sv
// CPU/video bus glue for CoCo/Dragon cores: clock-enable divider, SAM edge
// capture for the video address/data, and a prioritised CPU read-data mux.
module coco_bus_glue #(
    parameter int              NSRC          = 8,
    parameter int              DW            = 8,
    parameter int              AW            = 16,
    parameter int              DIV_NORMAL    = 3,
    parameter int              DIV_TURBO     = 2,
    parameter logic [NSRC-1:0] PASSTHRU_MASK = '0,
    parameter logic [DW-1:0]   DEFAULT_DATA  = {DW{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             turbo,
    output logic             clk_ena,
    input  logic [NSRC-1:0]  src_cs,
    input  logic [NSRC*DW-1:0] src_data,
    input  logic             clk_e,
    input  logic             clk_q,
    input  logic             ras_n,
    input  logic             cas_n,
    input  logic [AW/2-1:0]  ma,
    input  logic [DW-1:0]    vid_ram_q,
    output logic [DW-1:0]    cpu_din,
    output logic [AW-1:0]    vid_addr,
    output logic [DW-1:0]    vid_data,
    output logic             cs_multi
);

    localparam int         MW    = AW / 2;
    localparam int         SW    = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [3:0] DIV_N = 4'(DIV_NORMAL);
    localparam logic [3:0] DIV_T = 4'(DIV_TURBO);

    // ------------------------------------------------------------------
    // Clock-enable divider
    // ------------------------------------------------------------------
    logic       turbo_reg;
    logic [3:0] div_cnt_reg;
    logic [3:0] div_cnt_next;
    logic [3:0] div_last;
    logic       clk_ena_reg;
    logic       clk_ena_next;

    // A turbo change restarts the count so the new divisor starts cleanly.
    always_comb begin
        div_last     = (turbo_reg ? DIV_T : DIV_N) - 4'd1;
        div_cnt_next = div_cnt_reg + 4'd1;
        clk_ena_next = 1'b0;
        if (turbo != turbo_reg) begin
            div_cnt_next = '0;
        end else if (div_cnt_reg == div_last) begin
            div_cnt_next = '0;
            clk_ena_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            turbo_reg   <= 1'b0;
            div_cnt_reg <= '0;
            clk_ena_reg <= 1'b0;
        end else begin
            turbo_reg   <= turbo;
            div_cnt_reg <= div_cnt_next;
            clk_ena_reg <= clk_ena_next;
        end
    end

    assign clk_ena = clk_ena_reg;

    // ------------------------------------------------------------------
    // SAM edge detection, sampled only on enabled cycles
    // ------------------------------------------------------------------
    logic ras_reg;
    logic cas_reg;
    logic q_reg;
    logic ras_rise;
    logic ras_fall;
    logic cas_fall;
    logic q_rise;

    assign ras_rise = clk_ena_reg &  ras_n & ~ras_reg & clk_e;
    assign ras_fall = clk_ena_reg & ~ras_n &  ras_reg;
    assign cas_fall = clk_ena_reg & ~cas_n &  cas_reg;
    assign q_rise   = clk_ena_reg &  clk_q & ~q_reg;

    // RAS/CAS history resets high so the first rise needs a low sample first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ras_reg <= 1'b1;
            cas_reg <= 1'b1;
            q_reg   <= 1'b0;
        end else if (clk_ena_reg) begin
            ras_reg <= ras_n;
            cas_reg <= cas_n;
            q_reg   <= clk_q;
        end
    end

    // ------------------------------------------------------------------
    // Source selection
    // ------------------------------------------------------------------
    logic [DW-1:0] src_word [NSRC];
    logic          sel_valid;
    logic          sel_multi;
    logic [SW-1:0] sel_idx;
    logic [DW-1:0] sel_data;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            assign src_word[gi] = src_data[gi*DW +: DW];
        end
    endgenerate

    // Scan from the top so the lowest active index wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_multi = 1'b0;
        sel_idx   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (src_cs[i]) begin
                if (sel_valid) begin
                    sel_multi = 1'b1;
                end
                sel_valid = 1'b1;
                sel_idx   = SW'(i);
            end
        end
        sel_data = sel_valid ? src_word[sel_idx] : DEFAULT_DATA;
    end

    // ------------------------------------------------------------------
    // Capture and video registers
    // ------------------------------------------------------------------
    logic [DW-1:0] cap_reg;
    logic          cs_multi_reg;
    logic [AW-1:0] vid_addr_reg;
    logic [DW-1:0] vid_data_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_reg      <= DEFAULT_DATA;
            cs_multi_reg <= 1'b0;
        end else if (ras_rise) begin
            cap_reg      <= sel_data;
            cs_multi_reg <= sel_multi;
        end
    end

    // A simultaneous RAS/CAS fall keeps only the row half.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vid_addr_reg <= '0;
        end else if (ras_fall) begin
            vid_addr_reg[MW-1:0] <= ma;
        end else if (cas_fall) begin
            vid_addr_reg[AW-1:MW] <= ma;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vid_data_reg <= '0;
        end else if (q_rise) begin
            vid_data_reg <= vid_ram_q;
        end
    end

    // Passthrough sources bypass the capture latency using the live select.
    always_comb begin
        cpu_din = cap_reg;
        if (sel_valid && PASSTHRU_MASK[sel_idx]) begin
            cpu_din = sel_data;
        end
    end

    assign cs_multi = cs_multi_reg;
    assign vid_addr = vid_addr_reg;
    assign vid_data = vid_data_reg;

endmodule

// File: tb/tb_coco_bus_glue.sv
// Bench for coco_bus_glue: two instances (no passthrough / source 0
// passthrough) checked every cycle against a behavioural model plus literals.
module tb_coco_bus_glue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        turbo = 1'b0;
    logic [7:0]  src_cs = '0;
    logic [63:0] src_data = '0;
    logic        clk_e = 1'b0;
    logic        clk_q = 1'b0;
    logic        ras_n = 1'b1;
    logic        cas_n = 1'b1;
    logic [7:0]  ma = '0;
    logic [7:0]  vid_ram_q = '0;

    logic        clk_ena_a, clk_ena_b;
    logic [7:0]  cpu_din_a, cpu_din_b;
    logic [15:0] vid_addr_a, vid_addr_b;
    logic [7:0]  vid_data_a, vid_data_b;
    logic        cs_multi_a, cs_multi_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    coco_bus_glue #(.PASSTHRU_MASK(8'h00)) dut_a (
        .clk(clk), .reset(reset), .turbo(turbo), .clk_ena(clk_ena_a),
        .src_cs(src_cs), .src_data(src_data), .clk_e(clk_e), .clk_q(clk_q),
        .ras_n(ras_n), .cas_n(cas_n), .ma(ma), .vid_ram_q(vid_ram_q),
        .cpu_din(cpu_din_a), .vid_addr(vid_addr_a), .vid_data(vid_data_a),
        .cs_multi(cs_multi_a)
    );

    coco_bus_glue #(.PASSTHRU_MASK(8'h01)) dut_b (
        .clk(clk), .reset(reset), .turbo(turbo), .clk_ena(clk_ena_b),
        .src_cs(src_cs), .src_data(src_data), .clk_e(clk_e), .clk_q(clk_q),
        .ras_n(ras_n), .cas_n(cas_n), .ma(ma), .vid_ram_q(vid_ram_q),
        .cpu_din(cpu_din_b), .vid_addr(vid_addr_b), .vid_data(vid_data_b),
        .cs_multi(cs_multi_b)
    );

    // ---------------- behavioural model ----------------
    // Enable timing is modelled as "clocks elapsed since the last restart":
    // a pulse falls on every positive multiple of the active divisor.
    logic        m_turbo;
    int          m_phase;
    logic        m_ras, m_cas, m_q, m_multi;
    logic [7:0]  m_cap, m_vdata;
    logic [15:0] m_addr;

    function automatic bit exp_ena();
        int d;
        d = m_turbo ? 2 : 3;
        return (m_phase > 0) && ((m_phase % d) == 0);
    endfunction

    function automatic int first_src(logic [7:0] cs);
        for (int i = 0; i < 8; i++)
            if (cs[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] exp_cpu(logic [7:0] mask);
        int k;
        k = first_src(src_cs);
        if (k >= 0 && mask[k]) return src_data[k*8 +: 8];
        return m_cap;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_turbo <= 1'b0;
            m_phase <= 0;
            m_ras   <= 1'b1;
            m_cas   <= 1'b1;
            m_q     <= 1'b0;
            m_cap   <= 8'hFF;
            m_multi <= 1'b0;
            m_addr  <= '0;
            m_vdata <= '0;
        end else begin
            if (turbo != m_turbo) begin
                m_turbo <= turbo;
                m_phase <= 0;
            end else begin
                m_phase <= m_phase + 1;
            end
            if (exp_ena()) begin
                m_ras <= ras_n;
                m_cas <= cas_n;
                m_q   <= clk_q;
                if (ras_n && !m_ras && clk_e) begin
                    m_cap   <= (first_src(src_cs) < 0) ? 8'hFF
                                                       : src_data[first_src(src_cs)*8 +: 8];
                    m_multi <= ($countones(src_cs) > 1);
                end
                if (!ras_n && m_ras)      m_addr[7:0]  <= ma;
                else if (!cas_n && m_cas) m_addr[15:8] <= ma;
                if (clk_q && !m_q)        m_vdata      <= vid_ram_q;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #1;
        check("ena_a",   32'(clk_ena_a),  32'(exp_ena()));
        check("ena_b",   32'(clk_ena_b),  32'(exp_ena()));
        check("din_a",   32'(cpu_din_a),  32'(exp_cpu(8'h00)));
        check("din_b",   32'(cpu_din_b),  32'(exp_cpu(8'h01)));
        check("addr_a",  32'(vid_addr_a), 32'(m_addr));
        check("addr_b",  32'(vid_addr_b), 32'(m_addr));
        check("vdata_a", 32'(vid_data_a), 32'(m_vdata));
        check("vdata_b", 32'(vid_data_b), 32'(m_vdata));
        check("multi_a", 32'(cs_multi_a), 32'(m_multi));
        check("multi_b", 32'(cs_multi_b), 32'(m_multi));
    end

    // Wait for a negedge inside an enabled cycle; inputs set next are sampled.
    task automatic on_ena();
        int n;
        n = 0;
        @(negedge clk);
        while (!exp_ena() && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!exp_ena()) begin
            failures++;
            $display("FAIL ena_wait: no enable within 20 clks");
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string name);
        sample();
        $display("step %s: ena=%0b din_a=%02h din_b=%02h addr=%04h vdata=%02h multi=%0b",
                 name, clk_ena_a, cpu_din_a, cpu_din_b, vid_addr_a, vid_data_a, cs_multi_a);
    endtask

    initial begin
        int pulses;

        repeat (3) @(negedge clk);
        check("rst_din",   32'(cpu_din_a),  32'h00FF);
        check("rst_addr",  32'(vid_addr_a), 32'h0000);
        check("rst_ena",   32'(clk_ena_a),  32'h0);
        check("rst_multi", 32'(cs_multi_a), 32'h0);
        reset = 1'b1;

        // Normal divisor: 4 single-clock pulses in 12 clocks.
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            sample();
            if (clk_ena_a) pulses++;
        end
        check("div3_pulses", 32'(pulses), 32'd4);
        $display("div3: %0d pulses in 12 clks", pulses);

        // Turbo: restart, then first pulse two clocks after the change.
        @(negedge clk);
        turbo = 1'b1;
        sample();
        check("turbo_chg_ena", 32'(clk_ena_a), 32'h0);
        sample();
        check("turbo_p1", 32'(clk_ena_a), 32'h0);
        sample();
        check("turbo_p2", 32'(clk_ena_a), 32'h1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            sample();
            if (clk_ena_a) pulses++;
        end
        check("div2_pulses", 32'(pulses), 32'd4);
        $display("div2: %0d pulses in 8 clks", pulses);

        // Video address: row on RAS fall, column on CAS fall.
        on_ena(); ras_n = 1'b0; ma = 8'h34; step("ras_fall");
        check("addr_row", 32'(vid_addr_a), 32'h0034);
        on_ena(); cas_n = 1'b0; ma = 8'h12; step("cas_fall");
        check("addr_1234", 32'(vid_addr_a), 32'h1234);

        // Capture with two sources active: lowest index wins, multi flagged.
        on_ena();
        src_cs = 8'b0000_0110; src_data[15:8] = 8'h3C; src_data[23:16] = 8'hA5;
        clk_e = 1'b1; ras_n = 1'b1;
        step("cap_multi");
        check("cap_3c",    32'(cpu_din_a),  32'h3C);
        check("cap_3c_b",  32'(cpu_din_b),  32'h3C);
        check("multi_one", 32'(cs_multi_a), 32'h1);

        // No source selected returns the default.
        on_ena(); ras_n = 1'b0; ma = 8'h56; step("ras_fall2");
        check("addr_1256", 32'(vid_addr_a), 32'h1256);
        on_ena(); src_cs = 8'h00; ras_n = 1'b1; step("cap_none");
        check("cap_ff",     32'(cpu_din_a),  32'hFF);
        check("multi_zero", 32'(cs_multi_a), 32'h0);

        // RAS rise with clk_e low is ignored.
        on_ena(); ras_n = 1'b0; step("ras_fall3");
        on_ena(); clk_e = 1'b0; src_cs = 8'b0000_0110; ras_n = 1'b1; step("cap_e_low");
        check("cap_e_low",   32'(cpu_din_a),  32'hFF);
        check("multi_e_low", 32'(cs_multi_a), 32'h0);

        // Simultaneous RAS/CAS fall keeps only the row half.
        on_ena(); cas_n = 1'b1; step("cas_rise");
        on_ena(); ras_n = 1'b0; cas_n = 1'b0; ma = 8'h77; step("ras_cas_fall");
        check("addr_1277", 32'(vid_addr_a), 32'h1277);

        // Video data latched on Q rise only.
        on_ena(); clk_q = 1'b1; vid_ram_q = 8'hC3; step("q_rise");
        check("vdata_c3", 32'(vid_data_a), 32'hC3);
        on_ena(); clk_q = 1'b0; vid_ram_q = 8'h11; step("q_fall");
        check("vdata_hold", 32'(vid_data_a), 32'hC3);

        // Passthrough on source 0 follows live data within the cycle.
        @(negedge clk);
        src_cs = 8'h01; src_data[7:0] = 8'h00;
        #1;
        check("pass_00",    32'(cpu_din_b), 32'h00);
        check("nopass_hold", 32'(cpu_din_a), 32'hFF);
        #2;
        src_data[7:0] = 8'h5A;
        #1;
        check("pass_5a", 32'(cpu_din_b), 32'h5A);
        $display("passthru: din_a=%02h din_b=%02h", cpu_din_a, cpu_din_b);

        // Asynchronous reset between edges with a RAS rise pending.
        @(negedge clk);
        ras_n = 1'b1; clk_e = 1'b1; src_cs = 8'b0000_0110;
        #2;
        reset = 1'b0;
        #1;
        check("arst_din",   32'(cpu_din_a),  32'h00FF);
        check("arst_addr",  32'(vid_addr_a), 32'h0000);
        check("arst_ena",   32'(clk_ena_a),  32'h0);
        check("arst_vdata", 32'(vid_data_a), 32'h00);
        check("arst_multi", 32'(cs_multi_a), 32'h0);
        $display("async reset: din=%02h addr=%04h ena=%0b", cpu_din_a, vid_addr_a, clk_ena_a);
        @(negedge clk);
        reset = 1'b1;
        on_ena(); step("post_reset");
        check("post_rst_din",   32'(cpu_din_a),  32'hFF);
        check("post_rst_multi", 32'(cs_multi_a), 32'h0);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
